channel_rx_buffer: RTL

CHANNEL_RX_BUFFER -- requirements
Module: channel_rx_buffer

---
 rtl/channel_pkg.sv | 20 ++
 rtl/channel_rx_buffer_if.sv | 35 +++
 rtl/channel_fifo_mem.sv | 32 +++
 rtl/channel_rx_buffer.sv | 116 +++++++++++
 4 files changed

// File: rtl/channel_pkg.sv
// Package: channel_pkg
// Purpose : default build constants and the channel word type shared by the
//           channel receive buffer, its interface and its storage sub-module.
// Contents: DEF_DATA_WIDTH, DEF_DEPTH, DEF_SUSPEND_SLACK, channel_word_t,
//           level_width() helper.
package channel_pkg;

   localparam int DEF_DATA_WIDTH    = 8;
   localparam int DEF_DEPTH         = 16;
   localparam int DEF_SUSPEND_SLACK = 2;

   typedef logic [DEF_DATA_WIDTH-1:0] channel_word_t;

   // Occupancy needs one bit more than the pointers so that "full" (== DEPTH)
   // is representable.
   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/channel_rx_buffer_if.sv
// Interface: channel_rx_buffer_if
// Purpose  : groups the sender side (data_vld/data/suspend), the consumer
//            side (out_vld/out_data/out_rdy) and the status/control signals
//            (level/overflow/clear_ovf) of the channel receive buffer.
// Modports : slave  - the buffer itself
//            master - the environment driving the buffer (sender + consumer)
interface channel_rx_buffer_if
   import channel_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH
);
   localparam int LW = level_width(DEPTH);

   logic                  data_vld;
   logic [DATA_WIDTH-1:0] data;
   logic                  suspend;
   logic                  out_vld;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_rdy;
   logic [LW-1:0]         level;
   logic                  overflow;
   logic                  clear_ovf;

   modport slave (
      input  data_vld, data, out_rdy, clear_ovf,
      output suspend, out_vld, out_data, level, overflow
   );

   modport master (
      output data_vld, data, out_rdy, clear_ovf,
      input  suspend, out_vld, out_data, level, overflow
   );

endinterface

// File: rtl/channel_fifo_mem.sv
// Module : channel_fifo_mem
// Purpose: DEPTH x DATA_WIDTH storage for the channel receive buffer.
//          One synchronous write port, one asynchronous read port, no reset.
// Ports  : clock        - write clock
//          we/waddr/wdata - write port
//          raddr/rdata  - combinational read port
module channel_fifo_mem
   import channel_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic                  clock,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/channel_rx_buffer.sv
// Module : channel_rx_buffer
// Purpose: receive-side FIFO for a channel with registered suspend flow
//          control and a sticky overflow flag. Words arriving while full
//          are dropped unless the consumer pops in the same cycle.
// Ports  : clock, reset (async, active high)
//          bus (channel_rx_buffer_if.slave):
//             data_vld/data  in  - incoming channel word
//             suspend        out - ask sender to stop (registered)
//             out_vld/out_data/out_rdy - head entry handshake
//             level          out - occupancy 0..DEPTH
//             overflow       out - sticky drop flag, clear_ovf clears it
//          rx_count/drop_count out - only when CHANNEL_RX_STATS_EN is
//             defined; saturating counts of accepted and dropped words.
module channel_rx_buffer
   import channel_pkg::*;
#(
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int DEPTH         = DEF_DEPTH,
   parameter int SUSPEND_SLACK = DEF_SUSPEND_SLACK
) (
   input  logic        clock,
   input  logic        reset,
   channel_rx_buffer_if.slave bus
`ifdef CHANNEL_RX_STATS_EN
   ,
   output logic [31:0] rx_count,
   output logic [31:0] drop_count
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = level_width(DEPTH);
   localparam logic [LW-1:0] FULL_LVL   = LW'(DEPTH);
   localparam logic [LW-1:0] SUSP_LVL   = LW'(DEPTH - SUSPEND_SLACK);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [LW-1:0] level_q;
   logic [LW-1:0] next_level;
   logic          suspend_q;
   logic          overflow_q;
   logic          push;
   logic          pop;
   logic          drop;

   always_comb begin
      pop        = 1'b0;
      push       = 1'b0;
      drop       = 1'b0;
      next_level = level_q;
      pop  = (level_q != '0) && bus.out_rdy;
      // A full buffer still accepts a word if the head leaves this cycle.
      push = bus.data_vld && ((level_q != FULL_LVL) || pop);
      drop = bus.data_vld && !push;
      next_level = level_q + {{(LW-1){1'b0}}, push} - {{(LW-1){1'b0}}, pop};
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level_q    <= '0;
         suspend_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         level_q   <= next_level;
         suspend_q <= (next_level >= SUSP_LVL);
         // A new drop wins over a simultaneous clear.
         if (drop) begin
            overflow_q <= 1'b1;
         end else if (bus.clear_ovf) begin
            overflow_q <= 1'b0;
         end
      end
   end

   channel_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem (
      .clock (clock),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (bus.data),
      .raddr (rd_ptr),
      .rdata (bus.out_data)
   );

   assign bus.out_vld  = (level_q != '0);
   assign bus.level    = level_q;
   assign bus.suspend  = suspend_q;
   assign bus.overflow = overflow_q;

`ifdef CHANNEL_RX_STATS_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_count   <= '0;
         drop_count <= '0;
      end else begin
         if (push && (rx_count != 32'hFFFF_FFFF)) begin
            rx_count <= rx_count + 32'd1;
         end
         if (drop && (drop_count != 32'hFFFF_FFFF)) begin
            drop_count <= drop_count + 32'd1;
         end
      end
   end
`endif

endmodule
